// File: rtl/ram_arb_pkg.sv
// ---------------------------------------------------------------------------
// ram_arb_pkg
// Shared definitions for the single-port RAM arbiter:
//   SIDE_A / SIDE_B : requester encodings used by the grant pointer and read tag
//   rd_tag_t        : read-return tag (valid + requester side), one cycle deep
//   calc_aw()       : address width for a given RAM depth (minimum 1 bit)
// ---------------------------------------------------------------------------
package ram_arb_pkg;

  localparam logic SIDE_A = 1'b0;
  localparam logic SIDE_B = 1'b1;

  typedef struct packed {
    logic valid;
    logic side;
  } rd_tag_t;

  // A depth of 1 still needs a 1-bit address port to keep the buses legal.
  function automatic int calc_aw(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/ram_1port_arbiter_rr.sv
// ---------------------------------------------------------------------------
// rr_arbiter_2
// Two-way round-robin grant with a registered priority pointer.
// Ports:
//   i_Clk    : clock, rising edge
//   i_Rst    : synchronous active-high reset (pointer returns to A)
//   i_Req    : request vector, bit 0 = A, bit 1 = B
//   i_Accept : a grant was actually taken this cycle (advances the pointer)
//   o_Gnt    : one-hot grant (combinational), all zero when nothing requests
// ---------------------------------------------------------------------------
module rr_arbiter_2
  import ram_arb_pkg::*;
(
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic [1:0] i_Req,
  input  logic       i_Accept,
  output logic [1:0] o_Gnt
);

  logic r_Prio;

  // The pointer only matters under contention; a lone requester always wins.
  always_comb begin
    o_Gnt = 2'b00;
    case (i_Req)
      2'b01:   o_Gnt = 2'b01;
      2'b10:   o_Gnt = 2'b10;
      2'b11:   o_Gnt = (r_Prio == SIDE_B) ? 2'b10 : 2'b01;
      default: o_Gnt = 2'b00;
    endcase
  end

  // After any acceptance the other side gets priority next time.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_Prio <= SIDE_A;
    end else if (i_Accept) begin
      r_Prio <= o_Gnt[0] ? SIDE_B : SIDE_A;
    end
  end

endmodule

// File: rtl/ram_1port_arbiter.sv
// ---------------------------------------------------------------------------
// ram_1port_arbiter
// Shares one single-port synchronous RAM (registered read) between two
// requesters A and B using round-robin arbitration. Commands are accepted
// with a valid/ready handshake and driven onto the RAM in the same cycle;
// read data returns one cycle later on a per-requester data-valid strobe.
// Ports (X = A or B):
//   i_Clk, i_Rst            : clock, synchronous active-high reset
//   i_X_Valid / o_X_Ready   : command handshake (ready is combinational)
//   i_X_WE, i_X_Addr        : write(1)/read(0), word address
//   i_X_Wr_Data             : write data
//   o_X_Rd_DV, o_X_Rd_Data  : read return strobe and data (data 0 when idle)
//   o_Ram_WE, o_Ram_Addr,
//   o_Ram_Wr_Data           : RAM command, zero when nothing is granted
//   i_Ram_Rd_Data           : RAM registered read data
// ---------------------------------------------------------------------------
module ram_1port_arbiter
  import ram_arb_pkg::*;
#(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 256,
  localparam int AW    = calc_aw(DEPTH)
) (
  input  logic             i_Clk,
  input  logic             i_Rst,

  input  logic             i_A_Valid,
  input  logic             i_A_WE,
  input  logic [AW-1:0]    i_A_Addr,
  input  logic [WIDTH-1:0] i_A_Wr_Data,
  output logic             o_A_Ready,
  output logic             o_A_Rd_DV,
  output logic [WIDTH-1:0] o_A_Rd_Data,

  input  logic             i_B_Valid,
  input  logic             i_B_WE,
  input  logic [AW-1:0]    i_B_Addr,
  input  logic [WIDTH-1:0] i_B_Wr_Data,
  output logic             o_B_Ready,
  output logic             o_B_Rd_DV,
  output logic [WIDTH-1:0] o_B_Rd_Data,

  output logic             o_Ram_WE,
  output logic [AW-1:0]    o_Ram_Addr,
  output logic [WIDTH-1:0] o_Ram_Wr_Data,
  input  logic [WIDTH-1:0] i_Ram_Rd_Data
);

  logic [1:0] w_Gnt;
  logic       w_Acc_A;
  logic       w_Acc_B;
  logic       w_Accept;
  logic       w_A_DV;
  logic       w_B_DV;
  rd_tag_t    r_Rd_Tag;

  rr_arbiter_2 u_rr (
    .i_Clk    (i_Clk),
    .i_Rst    (i_Rst),
    .i_Req    ({i_B_Valid, i_A_Valid}),
    .i_Accept (w_Accept),
    .o_Gnt    (w_Gnt)
  );

  // A grant only exists for a valid requester, so ready alone implies acceptance.
  assign o_A_Ready = w_Gnt[0] & ~i_Rst;
  assign o_B_Ready = w_Gnt[1] & ~i_Rst;
  assign w_Acc_A   = o_A_Ready & i_A_Valid;
  assign w_Acc_B   = o_B_Ready & i_B_Valid;
  assign w_Accept  = w_Acc_A | w_Acc_B;

  always_comb begin
    o_Ram_WE      = 1'b0;
    o_Ram_Addr    = '0;
    o_Ram_Wr_Data = '0;
    if (w_Acc_A) begin
      o_Ram_WE      = i_A_WE;
      o_Ram_Addr    = i_A_Addr;
      o_Ram_Wr_Data = i_A_Wr_Data;
    end else if (w_Acc_B) begin
      o_Ram_WE      = i_B_WE;
      o_Ram_Addr    = i_B_Addr;
      o_Ram_Wr_Data = i_B_Wr_Data;
    end
  end

  // Tag follows the RAM's one-cycle read register; writes never raise it.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_Rd_Tag <= '0;
    end else begin
      r_Rd_Tag.valid <= w_Accept & ~o_Ram_WE;
      r_Rd_Tag.side  <= w_Acc_B ? SIDE_B : SIDE_A;
    end
  end

  // Gating with reset kills a return that lands in the first reset cycle.
  assign w_A_DV = r_Rd_Tag.valid & (r_Rd_Tag.side == SIDE_A) & ~i_Rst;
  assign w_B_DV = r_Rd_Tag.valid & (r_Rd_Tag.side == SIDE_B) & ~i_Rst;

  assign o_A_Rd_DV   = w_A_DV;
  assign o_B_Rd_DV   = w_B_DV;
  assign o_A_Rd_Data = w_A_DV ? i_Ram_Rd_Data : '0;
  assign o_B_Rd_Data = w_B_DV ? i_Ram_Rd_Data : '0;

endmodule

// File: doc/ram_1port_arbiter.md
Name: ram_1port_arbiter

Overview:
- Shares one single-port synchronous RAM (1-cycle registered read, write-and-read same address per clock) between two requesters, A and B.
- Uses round-robin arbitration.
- Each requester issues read/write commands through a valid/ready handshake.
- Read data returns on a per-requester data-valid strobe a fixed 1 cycle after acceptance.
- Sits between client logic (e.g. a UART buffer and a processing engine) and the RAM instance.

Parameters:
- WIDTH, 16, data width of the RAM word and of both requester data buses.
- DEPTH, 256, number of RAM words; address width AW = $clog2(DEPTH).

Ports:
- i_Clk  in  1  single clock; all logic on rising edge.
- i_Rst  in  1  synchronous, active-high reset.
- i_A_Valid  in  1  requester A command present.
- i_A_WE  in  1  A command is write (1) or read (0).
- i_A_Addr  in  AW  A address.
- i_A_Wr_Data  in  WIDTH  A write data.
- o_A_Ready  out  1  A command accepted this cycle (combinational).
- o_A_Rd_DV  out  1  A read data valid.
- o_A_Rd_Data  out  WIDTH  A read data.
- i_B_*/o_B_*  same set of seven ports for requester B.
- o_Ram_WE  out  1  to RAM write enable.
- o_Ram_Addr  out  AW  to RAM address.
- o_Ram_Wr_Data  out  WIDTH  to RAM write data.
- i_Ram_Rd_Data  in  WIDTH  from RAM registered read data.

Behaviour:
- Grant logic (combinational):
  - Only A valid -> grant A.
  - Only B valid -> grant B.
  - Both valid -> grant the side indicated by priority pointer r_Prio (0=A, 1=B).
  - Neither valid -> no grant.
- o_X_Ready = grant to X and not i_Rst. A command is accepted on the cycle where i_X_Valid & o_X_Ready.
- Requester must hold Valid/WE/Addr/Wr_Data stable until accepted; the arbiter does not buffer commands.
- RAM drive (combinational, same cycle as acceptance):
  - o_Ram_Addr = granted Addr.
  - o_Ram_WE = granted WE.
  - o_Ram_Wr_Data = granted Wr_Data.
  - With no grant, or in reset: o_Ram_WE=0, o_Ram_Addr=0, o_Ram_Wr_Data=0.
- Pointer update (registered): on any acceptance, r_Prio <= the side NOT just granted. With no acceptance, r_Prio holds.
  - Back-to-back contention therefore alternates A,B,A,B.
  - A sole requester may issue every cycle.
- Read return pipeline:
  - On acceptance of a read, register r_Rd_Tag = {valid=1, side}; otherwise r_Rd_Tag.valid <= 0.
  - Next cycle: o_X_Rd_DV = r_Rd_Tag.valid & (side==X), and o_X_Rd_Data = i_Ram_Rd_Data when DV is high, else 0.
  - Read latency is exactly 1 cycle from acceptance.
  - Reads are pipelined at full rate: one result per cycle.
- Writes: no return strobe; the write completes at the acceptance edge.
  - A read of the same address in the following cycle returns the new data.
  - A write does not generate Rd_DV even though the RAM updates its read register.
- Reset:
  - While i_Rst=1: r_Prio<=0 (A first), r_Rd_Tag.valid<=0, all Ready=0, all Rd_DV=0, all Rd_Data=0, Ram WE=0.
  - Reset asserted the cycle after a read acceptance suppresses that read's Rd_DV.
  - No command is accepted during reset.
- Simultaneous events: an A read and a B write both valid -> only one is granted. The loser's Ready=0 and it retries with held inputs next cycle.
- Address range: addresses >= DEPTH (non-power-of-2 DEPTH) are passed through unchecked. Their behaviour is RAM-defined and outside scope.

Decomposition:
- Shared package ram_arb_pkg:
  - localparam SIDE_A=1'b0, SIDE_B=1'b1.
  - Typedef rd_tag_t {logic valid; logic side;}.
  - Function for the AW calculation.
- One natural sub-module: rr_arbiter_2, the 2-way round-robin grant plus r_Prio register (inputs: req[1:0], accept; output: gnt[1:0]).
- The arbiter top adds the muxing and read-tag pipeline. The RAM itself is instantiated outside this block.

Test Plan:
- Reset then idle -> Ready A/B=0 during reset; after release, with no valids, Ram WE=0, Addr=0, no Rd_DV.
- A writes 0x1234 @0x10, then A reads @0x10 -> Ready high each cycle; o_A_Rd_DV=1 exactly 1 cycle after the read acceptance with o_A_Rd_Data=0x1234; o_B_Rd_DV stays 0.
- A and B both read continuously for 6 cycles (A@0x01=0xAAAA, B@0x02=0xBBBB preloaded) -> grants A,B,A,B,A,B; Rd_DV alternates A,B one cycle later with correct data.
- Same cycle: A write 0x5555 @0x20 and B read @0x20, pointer=A -> A accepted first; B accepted next cycle; B receives 0x5555.
- Sole requester B reads @0x00..0x03 back-to-back -> accepted 4 consecutive cycles; 4 consecutive o_B_Rd_DV pulses with in-order data.
- A read accepted, i_Rst asserted next cycle -> no o_A_Rd_DV; after reset, pointer is back to A (A wins first contention).
